// File: rtl/ft_fifo_arbiter_pkg.sv
// ft_fifo_pkg: shared types and constants for the FT245-style synchronous FIFO
// bus arbiter.
//   state_t        arbiter FSM states
//   DIR_RX/DIR_TX  encoding of the dir output / grant direction
//   DEF_*          default parameter values
package ft_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RX_TURN  = 2'd1,
    ST_RX_BURST = 2'd2,
    ST_TX_BURST = 2'd3
  } state_t;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_MAX = 64;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/ft_fifo_arbiter_if.sv
// ft_fifo_arbiter_if: FT chip side of the synchronous FIFO bus.
//   ft_rxf_n     low = FT has RX data for us
//   ft_txe_n     low = FT can accept TX data
//   ft_data_in   bus value driven by the FT chip
//   ft_data_out  bus value driven by the FPGA (valid while ft_data_oe=1)
//   ft_data_oe   FPGA owns the bus
//   ft_oe_n      FT drives the bus (RX direction)
//   ft_rd_n      RX strobe: a word moves on every clock edge it is low
//   ft_wr_n      TX strobe: a word moves on every clock edge it is low
// Handshake: a word crosses the bus on a rising clk edge when the FT flag
// (rxf_n / txe_n) and the matching strobe (rd_n / wr_n) are both low.
// modport master = arbiter side, modport slave = FT chip side.
interface ft_fifo_arbiter_if
  import ft_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              ft_rxf_n;
  logic              ft_txe_n;
  logic [DATA_W-1:0] ft_data_in;
  logic [DATA_W-1:0] ft_data_out;
  logic              ft_data_oe;
  logic              ft_oe_n;
  logic              ft_rd_n;
  logic              ft_wr_n;

  modport master (
    input  ft_rxf_n, ft_txe_n, ft_data_in,
    output ft_data_out, ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n
  );

  modport slave (
    output ft_rxf_n, ft_txe_n, ft_data_in,
    input  ft_data_out, ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n
  );
endinterface

// File: rtl/ft_fifo_arbiter_dir_arbiter.sv
// ft_dir_arbiter: combinational round-robin choice between the RX and TX
// directions.
//   rx_ok, tx_ok  direction can move data now
//   dir           last granted direction
//   grant         some direction can be served
//   grant_dir     direction to serve (opposite of dir when both are ready)
module ft_dir_arbiter
  import ft_fifo_pkg::*;
(
  input  logic rx_ok,
  input  logic tx_ok,
  input  logic dir,
  output logic grant,
  output logic grant_dir
);
  always_comb begin
    grant = rx_ok | tx_ok;
    if (rx_ok && tx_ok) grant_dir = ~dir;
    else if (tx_ok)     grant_dir = DIR_TX;
    else                grant_dir = DIR_RX;
  end
endmodule

// File: rtl/ft_fifo_arbiter.sv
// ft_fifo_arbiter: moves words between an FT245-style synchronous FIFO bus
// and two local FIFOs (A receives RX data, B supplies TX data), alternating
// bursts of at most BURST_MAX words per direction.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   ft               FT bus (ft_fifo_arbiter_if.master)
//   ffa              FIFO A almost full (stop pushing)
//   a_wr_en/a_wr_data push into FIFO A
//   efb              FIFO B empty (first-word-fallthrough)
//   b_rd_data/b_rd_en FIFO B head word / pop
//   busy, dir        not idle / last granted direction (0 RX, 1 TX)
//   state            FSM state for observation
//   rx_words, tx_words  transfer counters, present only when the
//                    FT_FIFO_STATS_EN macro is defined
// All strobes are decoded combinationally from the registered state, so an
// asynchronous reset removes them immediately.
module ft_fifo_arbiter
  import ft_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  ft_fifo_arbiter_if.master ft,
  input  logic              ffa,
  output logic              a_wr_en,
  output logic [DATA_W-1:0] a_wr_data,
  input  logic              efb,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              b_rd_en,
  output logic              busy,
  output logic              dir,
  output state_t            state
`ifdef FT_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]  rx_words,
  output logic [CNT_W-1:0]  tx_words
`endif
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  // Configuration guard: an empty block, but it keeps illegal sizes visible.
  if (BURST_MAX < 1 || CNT_W < 1) begin : g_cfg_invalid
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          rx_ok, tx_ok, grant, grant_dir;

  assign rx_ok = ~ft.ft_rxf_n & ~ffa;
  assign tx_ok = ~ft.ft_txe_n & ~efb;

  ft_dir_arbiter u_dir_arbiter (
    .rx_ok    (rx_ok),
    .tx_ok    (tx_ok),
    .dir      (dir_q),
    .grant    (grant),
    .grant_dir(grant_dir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_TX;  // first contended grant then goes to RX
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    ft.ft_oe_n     = 1'b1;
    ft.ft_rd_n     = 1'b1;
    ft.ft_wr_n     = 1'b1;
    ft.ft_data_oe  = 1'b0;
    ft.ft_data_out = '0;
    a_wr_en        = 1'b0;
    b_rd_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          dir_d   = grant_dir;
          state_d = (grant_dir == DIR_TX) ? ST_TX_BURST : ST_RX_TURN;
        end
      end
      ST_RX_TURN: begin
        // FT takes the bus this cycle; no read strobe until it has.
        ft.ft_oe_n = 1'b0;
        state_d    = ST_RX_BURST;
      end
      ST_RX_BURST: begin
        ft.ft_oe_n = 1'b0;
        ft.ft_rd_n = ~rx_ok;
        a_wr_en    = rx_ok;
        if (!rx_ok || cnt_q == CNT_LAST) state_d = ST_IDLE;
        if (rx_ok) cnt_d = cnt_q + CW'(1);
      end
      ST_TX_BURST: begin
        ft.ft_data_oe  = 1'b1;
        ft.ft_data_out = b_rd_data;
        ft.ft_wr_n     = efb;
        b_rd_en        = tx_ok;
        if (!tx_ok || cnt_q == CNT_LAST) state_d = ST_IDLE;
        if (tx_ok) cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Every return to IDLE starts the next burst count from zero.
    if (state_d == ST_IDLE) cnt_d = '0;
  end

  assign a_wr_data = ft.ft_data_in;
  assign busy      = (state_q != ST_IDLE);
  assign dir       = dir_q;
  assign state     = state_q;

`ifdef FT_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_words <= '0;
      tx_words <= '0;
    end else begin
      rx_words <= rx_words + CNT_W'(a_wr_en);
      tx_words <= tx_words + CNT_W'(b_rd_en);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
